serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 213 +++++++++++++++++++++
 tb/tb_serial_subtractor.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Digit-serial two's-complement subtractor. An operation computes
// operand1 - operand2 as operand1 + ~operand2 + 1, one DIGIT-wide slice per
// clock, least significant slice first. The ripple carry between slices is
// held in a single flip-flop, so the adder is only DIGIT+1 bits wide no
// matter how large WIDTH gets.
//
// Parameters
//   WIDTH       operand/result width in bits (must be a multiple of DIGIT)
//   DIGIT       bits handled per RUN cycle (DIGIT == WIDTH is allowed)
//   ST_CARRY    statusOut bit index of the borrow flag
//   ST_ZERO     statusOut bit index of the zero flag
//   ST_NEG      statusOut bit index of the negative flag
//   ST_OVERFLOW statusOut bit index of the signed-overflow flag
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   start      in   1      request an operation (taken only while ready=1)
//   operand1   in   WIDTH  minuend, captured on the accepting edge
//   operand2   in   WIDTH  subtrahend, captured on the accepting edge
//   ready      out  1      high while idle
//   done       out  1      one-cycle pulse when result/statusOut update
//   result     out  WIDTH  registered difference, modulo 2^WIDTH
//   statusOut  out  4      registered {overflow, neg, zero, borrow}
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH       = 8,
  parameter int DIGIT       = 2,
  parameter int ST_CARRY    = 0,
  parameter int ST_ZERO     = 1,
  parameter int ST_NEG      = 2,
  parameter int ST_OVERFLOW = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       statusOut
);

  // Number of RUN cycles per operation and the counter that walks them.
  // A single-slice configuration still gets a one-bit counter so that the
  // vector declarations stay legal.
  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [WIDTH-1:0] r_op1;
  logic [WIDTH-1:0] r_op2;
  logic [WIDTH-1:0] r_diff;
  logic [CNT_W-1:0] r_count;
  logic             r_carry;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_status;

  logic [DIGIT-1:0] w_slice1;
  logic [DIGIT-1:0] w_slice2;
  logic [DIGIT:0]   w_sum;
  logic [WIDTH-1:0] w_diffNext;
  logic [3:0]       w_statusNext;
  logic             w_lastSlice;

  assign w_lastSlice = (r_count == LAST_SLICE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state decode and the handshake outputs. DONE always falls back to
  // IDLE, so back-to-back requests are spaced by IDLE + N*RUN + DONE cycles.
  always_comb begin
    w_stateNext = r_state;
    ready       = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          w_stateNext = RUN;
        end
      end
      RUN: begin
        if (w_lastSlice) begin
          w_stateNext = DONE;
        end
      end
      DONE: begin
        done        = 1'b1;
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Pick the slice of each latched operand addressed by the digit counter.
  // A compare-per-slice mux keeps the select free of variable part-selects.
  always_comb begin
    w_slice1 = '0;
    w_slice2 = '0;
    for (int k = 0; k < N; k++) begin
      if (r_count == CNT_W'(k)) begin
        w_slice1 = r_op1[k*DIGIT +: DIGIT];
        w_slice2 = r_op2[k*DIGIT +: DIGIT];
      end
    end
  end

  // One slice of op1 + ~op2 + carry; the top bit is the carry into the next
  // slice. The carry starts at 1, which supplies the +1 of the two's
  // complement negation of op2.
  assign w_sum = {1'b0, w_slice1} + {1'b0, ~w_slice2} + {{DIGIT{1'b0}}, r_carry};

  // Partial difference with the current slice merged in. On the final slice
  // this is the complete result, which lets result/statusOut be loaded on
  // the same edge that enters DONE.
  always_comb begin
    w_diffNext = r_diff;
    for (int k = 0; k < N; k++) begin
      if (r_count == CNT_W'(k)) begin
        w_diffNext[k*DIGIT +: DIGIT] = w_sum[DIGIT-1:0];
      end
    end
  end

  // Flags for the finished operation. A missing carry-out of the top slice
  // means a borrow occurred (op1 < op2 unsigned). Signed overflow is only
  // possible when the operand signs differ, and shows up as the result sign
  // disagreeing with the minuend sign.
  always_comb begin
    w_statusNext              = '0;
    w_statusNext[ST_CARRY]    = ~w_sum[DIGIT];
    w_statusNext[ST_ZERO]     = (w_diffNext == '0);
    w_statusNext[ST_NEG]      = w_diffNext[WIDTH-1];
    w_statusNext[ST_OVERFLOW] = (r_op1[WIDTH-1] != r_op2[WIDTH-1]) &&
                                (w_diffNext[WIDTH-1] != r_op1[WIDTH-1]);
  end

  // Operand capture and slice-by-slice datapath. Operands are only loaded
  // while idle, so start pulses and operand changes during RUN/DONE cannot
  // disturb an operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op1   <= '0;
      r_op2   <= '0;
      r_diff  <= '0;
      r_count <= '0;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op1   <= operand1;
            r_op2   <= operand2;
            r_diff  <= '0;
            r_count <= '0;
            r_carry <= 1'b1;
          end
        end
        RUN: begin
          r_diff  <= w_diffNext;
          r_carry <= w_sum[DIGIT];
          if (w_lastSlice) begin
            r_count <= '0;
          end else begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Visible result and flags change only on the edge entering DONE and are
  // held until the next completed operation, so an aborted operation never
  // leaves partial data on the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_status <= '0;
    end else if ((r_state == RUN) && w_lastSlice) begin
      r_result <= w_diffNext;
      r_status <= w_statusNext;
    end
  end

  assign result    = r_result;
  assign statusOut = r_status;

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//
// Directed bench for serial_subtractor with WIDTH=8, DIGIT=2 (four RUN
// cycles per operation). Expected results and flags are hand-computed
// constants; statusOut is written as {overflow, neg, zero, borrow}.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] operand1;
  logic [7:0] operand2;
  logic       ready;
  logic       done;
  logic [7:0] result;
  logic [3:0] statusOut;

  int checkCount = 0;
  int errorCount = 0;
  int cycle      = 0;

  serial_subtractor #(
    .WIDTH      (8),
    .DIGIT      (2),
    .ST_CARRY   (0),
    .ST_ZERO    (1),
    .ST_NEG     (2),
    .ST_OVERFLOW(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .operand1 (operand1),
    .operand2 (operand2),
    .ready    (ready),
    .done     (done),
    .result   (result),
    .statusOut(statusOut)
  );

  // 10 ns clock period.
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  // One full operation: accept, scramble the operand inputs, wait for done,
  // check latency/result/flags, then check the done pulse ends.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] expRes, input logic [3:0] expStat);
    int edges;
    checkOutput("readyBefore", 32'(ready), 32'd1);
    operand1 = a;
    operand2 = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    operand1 = 8'($urandom);
    operand2 = 8'($urandom);
    edges = 0;
    while (!done && edges < 20) begin
      tick();
      edges++;
    end
    checkOutput("latency", 32'(edges), 32'd4);
    checkOutput("result", 32'(result), 32'(expRes));
    checkOutput("status", 32'(statusOut), 32'(expStat));
    checkOutput("readyInDone", 32'(ready), 32'd0);
    tick();
    checkOutput("donePulseEnd", 32'(done), 32'd0);
    checkOutput("readyAfter", 32'(ready), 32'd1);
    checkOutput("resultHeld", 32'(result), 32'(expRes));
    checkOutput("statusHeld", 32'(statusOut), 32'(expStat));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int edges;
    int lastDone;
    int sawDone;
    logic [7:0] b2bA   [3];
    logic [7:0] b2bB   [3];
    logic [7:0] b2bRes [3];
    logic [3:0] b2bStat[3];

    rst      = 1'b1;
    start    = 1'b0;
    operand1 = 8'h00;
    operand2 = 8'h00;
    tick();
    tick();
    checkOutput("rstReady", 32'(ready), 32'd1);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstResult", 32'(result), 32'd0);
    checkOutput("rstStatus", 32'(statusOut), 32'd0);
    rst = 1'b0;
    tick();

    // Basic vectors.
    applyStimulus(8'h05, 8'h03, 8'h02, 4'b0000);
    applyStimulus(8'h00, 8'h01, 8'hFF, 4'b0101);
    applyStimulus(8'h80, 8'h01, 8'h7F, 4'b1000);
    applyStimulus(8'h33, 8'h33, 8'h00, 4'b0010);
    applyStimulus(8'h7F, 8'hFF, 8'h80, 4'b1101);
    applyStimulus(8'hFF, 8'h7F, 8'h80, 4'b0100);
    applyStimulus(8'hA5, 8'h5A, 8'h4B, 4'b1000);

    // Reset wins over start on the same edge.
    rst      = 1'b1;
    start    = 1'b1;
    operand1 = 8'h44;
    operand2 = 8'h11;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    checkOutput("rstPrioReady", 32'(ready), 32'd1);
    tick();
    checkOutput("rstPrioStillIdle", 32'(ready), 32'd1);
    checkOutput("rstPrioResult", 32'(result), 32'd0);

    // A start pulse during RUN must be ignored.
    operand1 = 8'h10;
    operand2 = 8'h01;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    operand1 = 8'h00;
    operand2 = 8'h00;
    tick();
    operand1 = 8'hFF;
    operand2 = 8'h00;
    start    = 1'b1;
    tick();
    start = 1'b0;
    edges = 2;
    while (!done && edges < 20) begin
      tick();
      edges++;
    end
    checkOutput("ignoreLatency", 32'(edges), 32'd4);
    checkOutput("ignoreResult", 32'(result), 32'h0F);
    checkOutput("ignoreStatus", 32'(statusOut), 32'd0);
    tick();

    // Reset in the second RUN cycle aborts with no done pulse.
    operand1 = 8'h05;
    operand2 = 8'h03;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abortReady", 32'(ready), 32'd1);
    checkOutput("abortDone", 32'(done), 32'd0);
    checkOutput("abortResult", 32'(result), 32'd0);
    checkOutput("abortStatus", 32'(statusOut), 32'd0);
    sawDone = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) sawDone++;
    end
    checkOutput("abortNoDone", 32'(sawDone), 32'd0);

    // Start held high: three operations back to back, six cycles apart.
    b2bA[0] = 8'h20; b2bB[0] = 8'h05; b2bRes[0] = 8'h1B; b2bStat[0] = 4'b0000;
    b2bA[1] = 8'h01; b2bB[1] = 8'h02; b2bRes[1] = 8'hFF; b2bStat[1] = 4'b0101;
    b2bA[2] = 8'h7F; b2bB[2] = 8'h80; b2bRes[2] = 8'hFF; b2bStat[2] = 4'b1101;
    operand1 = b2bA[0];
    operand2 = b2bB[0];
    start    = 1'b1;
    tick();
    lastDone = 0;
    for (int k = 0; k < 3; k++) begin
      edges = 0;
      while (!done && edges < 20) begin
        if (k > 0) checkOutput("b2bHeld", 32'(result), 32'(b2bRes[k-1]));
        tick();
        edges++;
      end
      checkOutput("b2bResult", 32'(result), 32'(b2bRes[k]));
      checkOutput("b2bStatus", 32'(statusOut), 32'(b2bStat[k]));
      if (k > 0) checkOutput("b2bSpacing", 32'(cycle - lastDone), 32'd6);
      lastDone = cycle;
      if (k < 2) begin
        operand1 = b2bA[k+1];
        operand2 = b2bB[k+1];
      end else begin
        start = 1'b0;
      end
      tick();
    end
    checkOutput("b2bFinalHeld", 32'(result), 32'(b2bRes[2]));
    checkOutput("b2bFinalReady", 32'(ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
